// File: rtl/module_alu_operand_loader.sv
// module_alu_operand_loader
//
// Operand front end for module_alu_sumador. Each rising edge of the load
// button captures the shared switch bus into the next slot: operand A,
// operand B, then the carry/flag-in (bit 0 only). Once the set is
// complete, the operands are held stable on the ALU inputs and the ALU's
// combinational result is registered one cycle later for the display.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_n_i          synchronous active-low reset
//   data_i           shared operand bus; bit 0 is the flag in the FLAG step
//   load_i           load request level; only its rising edge acts
//   clear_i          restart the load sequence, register contents kept
//   ALUResult_i      combinational result from the ALU
//   ALUA_o/ALUB_o    operands to the ALU
//   ALUFlagIn_o      flag/carry-in to the ALU
//   operands_valid_o complete operand set present (HOLD)
//   result_o         registered ALU result
//   result_valid_o   result_o belongs to the current operand set
//   state_o          FSM state code for the LEDs
//
// state  | meaning
// LOAD_A | waiting for the load that captures operand A
// LOAD_B | waiting for the load that captures operand B
// LOAD_F | waiting for the load that captures the flag
// HOLD   | full set on the ALU; next load starts a new set with A

module module_alu_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] ALUResult_i,
    output logic [WIDTH-1:0] ALUA_o,
    output logic [WIDTH-1:0] ALUB_o,
    output logic             ALUFlagIn_o,
    output logic             operands_valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        LOAD_F = 2'b10,
        HOLD   = 2'b11
    } state_t;

    state_t           state;
    state_t           nextState;
    logic             loadQ;
    logic             firstCycle;
    logic             loadEvt;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic             aluFlag;
    logic [WIDTH-1:0] result;
    logic             resultValid;

    // The first cycle after reset only arms the edge detector, so a button
    // already held while reset releases must be released and pressed again.
    assign loadEvt = load_i & ~loadQ & ~firstCycle;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= LOAD_A;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (clear_i) begin
            nextState = LOAD_A;
        end else if (loadEvt) begin
            case (state)
                LOAD_A:  nextState = LOAD_B;
                LOAD_B:  nextState = LOAD_F;
                LOAD_F:  nextState = HOLD;
                HOLD:    nextState = LOAD_B;
                default: nextState = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            loadQ       <= 1'b0;
            firstCycle  <= 1'b1;
            aluA        <= '0;
            aluB        <= '0;
            aluFlag     <= 1'b0;
            result      <= '0;
            resultValid <= 1'b0;
        end else begin
            loadQ      <= load_i;
            firstCycle <= 1'b0;

            if (!clear_i && loadEvt) begin
                case (state)
                    LOAD_A, HOLD: aluA    <= data_i;
                    LOAD_B:       aluB    <= data_i;
                    LOAD_F:       aluFlag <= data_i[0];
                    default:      ;
                endcase
            end

            // resultValid is still low only on the first HOLD cycle, which
            // is the one edge where the ALU output is sampled.
            if (!clear_i && state == HOLD && !resultValid) begin
                result <= ALUResult_i;
            end

            if (clear_i) begin
                resultValid <= 1'b0;
            end else if (state == HOLD) begin
                resultValid <= ~loadEvt;
            end else begin
                resultValid <= 1'b0;
            end
        end
    end

    assign ALUA_o           = aluA;
    assign ALUB_o           = aluB;
    assign ALUFlagIn_o      = aluFlag;
    assign operands_valid_o = (state == HOLD);
    assign result_o         = result;
    assign result_valid_o   = resultValid;
    assign state_o          = state;

endmodule

// File: tb/tb_module_alu_operand_loader.sv
// Bench for module_alu_operand_loader: directed scenarios followed by
// randomized button/clear/reset traffic, all checked against a behavioural
// model of the load sequence.

module tb_module_alu_operand_loader;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic             load = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] aluResult;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic             aluFlag;
    logic             opValid;
    logic [WIDTH-1:0] result;
    logic             resValid;
    logic [1:0]       stateOut;

    int nAsserts = 0;
    int nFails   = 0;

    // Model state: which slot the next press fills (0=A,1=B,2=flag,3=full set)
    logic [1:0]       mSlot;
    logic [WIDTH-1:0] mA, mB, mRes;
    logic             mF, mRv;
    logic             mPrevLoad, mJustReset;

    always #5 clk = ~clk;

    // ALU stand-in: plain sum with carry-in, wrapping at WIDTH bits
    assign aluResult = aluA + aluB + {{(WIDTH-1){1'b0}}, aluFlag};

    module_alu_operand_loader #(.WIDTH(WIDTH)) dut (
        .clk_i           (clk),
        .rst_n_i         (rstN),
        .data_i          (dataIn),
        .load_i          (load),
        .clear_i         (clear),
        .ALUResult_i     (aluResult),
        .ALUA_o          (aluA),
        .ALUB_o          (aluB),
        .ALUFlagIn_o     (aluFlag),
        .operands_valid_o(opValid),
        .result_o        (result),
        .result_valid_o  (resValid),
        .state_o         (stateOut)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic modelEdge();
        logic press;
        logic [WIDTH-1:0] sum;
        if (!rstN) begin
            mSlot = 0; mA = 0; mB = 0; mF = 0; mRes = 0; mRv = 0;
            mPrevLoad = 0; mJustReset = 1;
        end else begin
            press      = load && !mPrevLoad && !mJustReset;
            mPrevLoad  = load;
            mJustReset = 0;
            if (clear) begin
                mSlot = 0;
                mRv   = 0;
            end else if (mSlot == 3) begin
                if (!mRv) begin
                    sum  = mA + mB + WIDTH'(mF);
                    mRes = sum;
                end
                if (press) begin
                    mA    = dataIn;
                    mSlot = 1;
                    mRv   = 0;
                end else begin
                    mRv = 1;
                end
            end else if (press) begin
                if (mSlot == 0) mA = dataIn;
                else if (mSlot == 1) mB = dataIn;
                else mF = dataIn[0];
                mSlot = mSlot + 1;
            end
        end
    endtask

    task automatic checkAll();
        chk("aluA", aluA, mA);
        chk("aluB", aluB, mB);
        chk("aluFlag", aluFlag, mF);
        chk("state", stateOut, mSlot);
        chk("opValid", opValid, mSlot == 2'd3);
        chk("result", result, mRes);
        chk("resValid", resValid, mRv);
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic press(input logic [WIDTH-1:0] d);
        dataIn = d;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset with a busy bus and a toggling button
        dataIn = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            load = i[0];
            tick();
        end
        chk("rst_state", stateOut, 2'b00);
        chk("rst_aluA", aluA, 8'h00);
        rstN = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_opvalid", opValid, 1'b0);

        // Full sequence A1 + 0A + 0
        press(8'hA1);
        press(8'h0A);
        dataIn = 8'h00;
        load = 1'b1;
        tick();
        chk("full_opvalid", opValid, 1'b1);
        chk("full_resvalid_early", resValid, 1'b0);
        load = 1'b0;
        tick();
        chk("full_result", result, 8'hAB);
        chk("full_resvalid", resValid, 1'b1);
        tick();

        // Held button: one capture only
        clear = 1'b1; tick(); clear = 1'b0;
        dataIn = 8'h55;
        load = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        load = 1'b0;
        tick();
        chk("held_aluA", aluA, 8'h55);
        chk("held_state", stateOut, 2'b01);
        chk("held_aluB", aluB, 8'h0A);

        // Flag bit 0 and wrap-around, then a fourth load starts a new set
        clear = 1'b1; tick(); clear = 1'b0;
        press(8'hFF);
        press(8'h01);
        press(8'h03);
        chk("wrap_flag", aluFlag, 1'b1);
        chk("wrap_result", result, 8'h01);
        press(8'h10);
        chk("new_aluA", aluA, 8'h10);
        chk("new_state", stateOut, 2'b01);
        chk("new_resvalid", resValid, 1'b0);
        chk("new_result", result, 8'h01);

        // Clear beats a simultaneous load in LOAD_F
        press(8'h22);
        dataIn = 8'h00;
        load = 1'b1;
        clear = 1'b1;
        tick();
        chk("clr_state", stateOut, 2'b00);
        chk("clr_flag", aluFlag, 1'b1);
        chk("clr_aluA", aluA, 8'h10);
        chk("clr_aluB", aluB, 8'h22);
        clear = 1'b0;
        load = 1'b0;
        tick();

        // Reset mid-sequence with the button held across release
        press(8'h3C);
        load = 1'b1;
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_aluA", aluA, 8'h00);
        chk("midrst_state", stateOut, 2'b00);
        load = 1'b0;
        tick();
        press(8'h77);
        chk("midrst_reload", aluA, 8'h77);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int hi, lo;
            dataIn = WIDTH'($urandom);
            hi = $urandom_range(1, 3);
            lo = $urandom_range(2, 4);
            load = 1'b1;
            for (int i = 0; i < hi; i++) begin
                clear = ($urandom_range(0, 19) == 0);
                rstN  = ($urandom_range(0, 59) != 0);
                tick();
            end
            load = 1'b0;
            for (int i = 0; i < lo; i++) begin
                clear = ($urandom_range(0, 19) == 0);
                rstN  = ($urandom_range(0, 59) != 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
